// File: rtl/traffic_timer_pkg.sv
// Shared codes for the traffic light timer: interval select values and
// the phase timer state encoding.
package traffic_timer_pkg;

   localparam logic [1:0] SEL_BASE   = 2'd0;
   localparam logic [1:0] SEL_EXT    = 2'd1;
   localparam logic [1:0] SEL_YELLOW = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/phase_timer.sv
// Seconds countdown for one traffic light phase. Loads an interval on start,
// counts divider ticks down to zero and emits a single expired pulse.
module phase_timer #(
   parameter int COUNT_WIDTH       = 8,
   parameter int BASE_INTERVAL     = 5,
   parameter int EXTENDED_INTERVAL = 10,
   parameter int YELLOW_INTERVAL   = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic                   start,
   input  logic [1:0]             interval_sel,
   input  logic                   hold,
   output logic                   timer_reset,
   output logic                   busy,
   output logic                   expired,
   output logic [COUNT_WIDTH-1:0] remaining,
   output logic [1:0]             state_dbg
);
   import traffic_timer_pkg::*;

   localparam logic [COUNT_WIDTH-1:0] LP_BASE   = COUNT_WIDTH'(BASE_INTERVAL);
   localparam logic [COUNT_WIDTH-1:0] LP_EXT    = COUNT_WIDTH'(EXTENDED_INTERVAL);
   localparam logic [COUNT_WIDTH-1:0] LP_YELLOW = COUNT_WIDTH'(YELLOW_INTERVAL);
   localparam logic [COUNT_WIDTH-1:0] LP_ONE    = COUNT_WIDTH'(1);

   logic [1:0]             r_state;
   logic [COUNT_WIDTH-1:0] r_remaining;
   logic                   r_busy;
   logic                   r_expired;
   logic                   r_timer_reset;
   logic [COUNT_WIDTH-1:0] w_interval;
   logic                   w_interval_zero;

   // Reserved code 2'b11 falls back to the base interval.
   always_comb begin
      w_interval = LP_BASE;
      case (interval_sel)
         SEL_EXT:    w_interval = LP_EXT;
         SEL_YELLOW: w_interval = LP_YELLOW;
         default:    w_interval = LP_BASE;
      endcase
   end

   assign w_interval_zero = (w_interval == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_remaining   <= '0;
         r_busy        <= 1'b0;
         r_expired     <= 1'b0;
         r_timer_reset <= 1'b0;
      end else begin
         r_timer_reset <= 1'b0;
         r_expired     <= 1'b0;
         if (start) begin
            r_remaining   <= w_interval;
            r_timer_reset <= 1'b1;
            if (w_interval_zero) begin
               r_state   <= ST_DONE;
               r_busy    <= 1'b0;
               r_expired <= 1'b1;
            end else begin
               r_state <= ST_RUN;
               r_busy  <= 1'b1;
            end
         end else begin
            case (r_state)
               ST_RUN: begin
                  // Hold wins over a coincident tick, so that tick is lost.
                  if (hold) begin
                     r_state <= ST_PAUSE;
                  end else if (enable) begin
                     if (r_remaining <= LP_ONE) begin
                        r_remaining <= '0;
                        r_expired   <= 1'b1;
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                     end else begin
                        r_remaining <= r_remaining - LP_ONE;
                     end
                  end
               end
               ST_PAUSE: begin
                  if (!hold) r_state <= ST_RUN;
               end
               ST_DONE: begin
                  r_state     <= ST_IDLE;
                  r_remaining <= '0;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign timer_reset = r_timer_reset;
   assign busy        = r_busy;
   assign expired     = r_expired;
   assign remaining   = r_remaining;
   assign state_dbg   = r_state;

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer: default build plus a zero-yellow build
// driven from the same inputs.
module tb_phase_timer;
   import traffic_timer_pkg::*;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic       start;
   logic [1:0] interval_sel;
   logic       hold;

   logic       timer_reset, busy, expired;
   logic [7:0] remaining;
   logic [1:0] state_dbg;

   logic       z_timer_reset, z_busy, z_expired;
   logic [7:0] z_remaining;
   logic [1:0] z_state_dbg;

   int n_tests = 0;
   int n_fail  = 0;

   phase_timer u_dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
      .interval_sel(interval_sel), .hold(hold), .timer_reset(timer_reset),
      .busy(busy), .expired(expired), .remaining(remaining), .state_dbg(state_dbg)
   );

   phase_timer #(.YELLOW_INTERVAL(0)) u_dut_zero (
      .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
      .interval_sel(interval_sel), .hold(hold), .timer_reset(z_timer_reset),
      .busy(z_busy), .expired(z_expired), .remaining(z_remaining), .state_dbg(z_state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_start(input logic [1:0] sel);
      start = 1'b1;
      interval_sel = sel;
      step(1);
      start = 1'b0;
   endtask

   task automatic do_tick();
      enable = 1'b1;
      step(1);
      enable = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; start = 1'b0; interval_sel = 2'b00; hold = 1'b0;
      step(2);
      check_val("rst_remaining", remaining, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_expired", expired, 0);
      check_val("rst_timer_reset", timer_reset, 0);
      check_val("rst_state", state_dbg, ST_IDLE);
      reset_n = 1'b1;
      step(1);
      do_tick();
      check_val("idle_tick_remaining", remaining, 0);
      check_val("idle_tick_busy", busy, 0);

      // Base interval full countdown
      do_start(SEL_BASE);
      check_val("t1_load", remaining, 5);
      check_val("t1_treset", timer_reset, 1);
      check_val("t1_busy", busy, 1);
      check_val("t1_expired0", expired, 0);
      step(1);
      check_val("t1_treset_fall", timer_reset, 0);
      for (int k = 4; k >= 0; k--) begin
         step(6);
         do_tick();
         check_val("t1_count", remaining, k);
         check_val("t1_expired", expired, (k == 0) ? 1 : 0);
         check_val("t1_busy_cnt", busy, (k != 0) ? 1 : 0);
      end
      check_val("t1_state_done", state_dbg, ST_DONE);
      step(1);
      check_val("t1_expired_fall", expired, 0);
      check_val("t1_state_idle", state_dbg, ST_IDLE);
      check_val("t1_rem_idle", remaining, 0);
      step(7);
      do_tick();
      check_val("t1_no_second_pulse", expired, 0);

      // Yellow then reserved select
      do_start(SEL_YELLOW);
      check_val("t2_load", remaining, 2);
      step(7); do_tick();
      check_val("t2_rem1", remaining, 1);
      check_val("t2_exp_early", expired, 0);
      step(7); do_tick();
      check_val("t2_rem0", remaining, 0);
      check_val("t2_expired", expired, 1);
      step(1);
      do_start(2'b11);
      check_val("t2_reserved_load", remaining, 5);
      check_val("t2_reserved_busy", busy, 1);

      // Extended interval with a hold window
      do_start(SEL_EXT);
      check_val("t3_load", remaining, 10);
      for (int k = 9; k >= 7; k--) begin
         step(7); do_tick();
         check_val("t3_pre_hold", remaining, k);
      end
      hold = 1'b1;
      step(7); do_tick();
      check_val("t3_hold_drop_tick", remaining, 7);
      check_val("t3_state_pause", state_dbg, ST_PAUSE);
      check_val("t3_busy_pause", busy, 1);
      for (int i = 0; i < 2; i++) begin
         step(7); do_tick();
         check_val("t3_held", remaining, 7);
         check_val("t3_held_busy", busy, 1);
      end
      hold = 1'b0;
      step(1);
      check_val("t3_state_run", state_dbg, ST_RUN);
      for (int k = 6; k >= 0; k--) begin
         step(7); do_tick();
         check_val("t3_resume", remaining, k);
         check_val("t3_expired", expired, (k == 0) ? 1 : 0);
      end
      step(1);

      // Start coincident with tick, then restart mid-run
      do_start(SEL_BASE);
      step(7); do_tick();
      step(7); do_tick();
      check_val("t4_rem3", remaining, 3);
      step(7);
      enable = 1'b1;
      do_start(SEL_EXT);
      enable = 1'b0;
      check_val("t4_start_prio", remaining, 10);
      check_val("t4_treset", timer_reset, 1);
      step(7); do_tick();
      check_val("t4_rem9", remaining, 9);
      step(3);
      do_start(SEL_YELLOW);
      check_val("t4_restart", remaining, 2);
      check_val("t4_no_abort_exp", expired, 0);
      check_val("t4_state_run", state_dbg, ST_RUN);
      step(7); do_tick();
      check_val("t4_rem1", remaining, 1);
      check_val("t4_exp_early", expired, 0);
      step(7); do_tick();
      check_val("t4_rem0", remaining, 0);
      check_val("t4_expired", expired, 1);
      step(1);

      // Asynchronous reset mid-countdown
      do_start(SEL_BASE);
      step(7); do_tick();
      check_val("t5_rem4", remaining, 4);
      #3 reset_n = 1'b0;
      #1;
      check_val("t5_rst_rem", remaining, 0);
      check_val("t5_rst_busy", busy, 0);
      check_val("t5_rst_expired", expired, 0);
      check_val("t5_rst_treset", timer_reset, 0);
      check_val("t5_rst_state", state_dbg, ST_IDLE);
      #2 reset_n = 1'b1;
      step(1);
      do_tick();
      check_val("t5_post_tick_rem", remaining, 0);
      check_val("t5_post_tick_busy", busy, 0);
      step(7); do_tick();
      check_val("t5_post_tick2_exp", expired, 0);

      // Zero-length yellow build
      do_start(SEL_YELLOW);
      check_val("t6_rem", z_remaining, 0);
      check_val("t6_expired", z_expired, 1);
      check_val("t6_treset", z_timer_reset, 1);
      check_val("t6_busy", z_busy, 0);
      check_val("t6_state_done", z_state_dbg, ST_DONE);
      check_val("t6_main_rem", remaining, 2);
      step(1);
      check_val("t6_state_idle", z_state_dbg, ST_IDLE);
      check_val("t6_expired_fall", z_expired, 0);
      check_val("t6_treset_fall", z_timer_reset, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
